muldiv_ctrl: RTL

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_datapath.sv | 124 ++++++++++++
 rtl/muldiv_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative
// RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;
  localparam int CNT_W    = 6;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add / restoring-divide iteration with
// sign fix-up and corner-case results.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic            fin,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            special,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MIN =
    {1'b1, {(XLEN-1){1'b0}}};

  logic [2:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   opb_q;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;

  logic              is_div;
  logic              sa;
  logic              sb;
  logic              neg_d;
  logic              div0;
  logic              ovf;
  logic [XLEN-1:0]   a_abs;
  logic [XLEN-1:0]   b_abs;
  logic [XLEN-1:0]   spec_val;
  logic [XLEN:0]     sum;
  logic [XLEN:0]     shl;
  logic [XLEN:0]     diff;
  logic [XLEN-1:0]   hi_d;
  logic [XLEN-1:0]   lo_d;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   res_d;

  always_comb begin
    is_div = funct3[2];
    sa = rs1[XLEN-1] & (funct3 inside
      {F3_MUL, F3_MULH, F3_MULHSU,
       F3_DIV, F3_REM});
    sb = rs2[XLEN-1] & (funct3 inside
      {F3_MUL, F3_MULH, F3_DIV, F3_REM});
    a_abs = sa ? -rs1 : rs1;
    b_abs = sb ? -rs2 : rs2;
    // remainder takes the dividend's sign
    neg_d = (is_div && funct3[1]) ? sa : sa ^ sb;
    div0 = is_div && (rs2 == '0);
    ovf = is_div && !funct3[0] &&
      (rs1 == MIN) && (rs2 == '1);
    special = div0 | ovf;
    spec_val = '0;
    unique case (1'b1)
      div0 && !funct3[1]:  spec_val = '1;
      div0 && funct3[1]:   spec_val = rs1;
      !div0 && !funct3[1]: spec_val = MIN;
      default:             spec_val = '0;
    endcase
  end

  always_comb begin
    sum = {1'b0, hi_q} +
      (lo_q[0] ? {1'b0, opb_q} : '0);
    shl = {hi_q, lo_q[XLEN-1]};
    diff = shl - {1'b0, opb_q};
    hi_d = '0;
    lo_d = '0;
    if (op_q[2]) begin
      hi_d = diff[XLEN] ? shl[XLEN-1:0]
                        : diff[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], ~diff[XLEN]};
    end else begin
      hi_d = sum[XLEN:1];
      lo_d = {sum[0], lo_q[XLEN-1:1]};
    end
    prod = neg_q ? -{hi_d, lo_d} : {hi_d, lo_d};
    res_d = '0;
    unique case (1'b1)
      op_q == F3_MUL:
        res_d = prod[XLEN-1:0];
      !op_q[2] && op_q != F3_MUL:
        res_d = prod[2*XLEN-1:XLEN];
      op_q[2] && !op_q[1]:
        res_d = neg_q ? -lo_d : lo_d;
      default:
        res_d = neg_q ? -hi_d : hi_d;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      neg_q  <= 1'b0;
      opb_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      result <= '0;
    end else begin
      if (load) begin
        op_q  <= funct3;
        neg_q <= neg_d;
        hi_q  <= '0;
        opb_q <= is_div ? b_abs : a_abs;
        lo_q  <= is_div ? a_abs : b_abs;
        if (special) result <= spec_val;
      end
      if (step) begin
        hi_q <= hi_d;
        lo_q <= lo_d;
      end
      if (fin) result <= res_d;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the M-extension unit: FSM,
// iteration counter and pipeline handshake.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            stall
);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             load;
  logic             step;
  logic             last;
  logic             fin;
  logic             special;

  assign load  = (state_q == S_IDLE) && start && !flush;
  assign step  = (state_q == S_CALC) && !flush;
  assign last  = cnt_q == CNT_W'(XLEN - 1);
  assign fin   = step && last;
  assign stall = load || (state_q == S_CALC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (flush) begin
      state_q <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            cnt_q <= '0;
            busy  <= 1'b1;
            // corner cases bypass iteration
            if (special) begin
              state_q <= S_DONE;
              done    <= 1'b1;
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            state_q <= S_DONE;
            done    <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  muldiv_datapath #(
    .XLEN(XLEN)
  ) u_dp (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .step   (step),
    .fin    (fin),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .special(special),
    .result (result)
  );

endmodule
